// File: rtl/i2c_reg16_target_pkg.sv
// Shared types and constants for the I2C 16-bit-pointer register target.
package i2c_reg16_target_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADDR,
    ST_ACK_DEV,
    ST_ADDR_HI,
    ST_ACK_HI,
    ST_ADDR_LO,
    ST_ACK_LO,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_MACK
  } state_e;

endpackage

// File: rtl/i2c_reg16_target_if.sv
// Register-side bus between the I2C target and a register file.
interface i2c_reg16_target_if;
  import i2c_reg16_target_pkg::*;

  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_rd;
  logic [DATA_W-1:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_rd, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_rd, output reg_rdata);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_now;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_now    = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_now;
    sda_prev_d = sda_s;
    scl_rise_c = scl_now & ~scl_prev_q;
    scl_fall_c = ~scl_now & scl_prev_q;
    // SDA moving while SCL is held high marks a bus condition
    start_c    = scl_now & scl_prev_q & sda_prev_q & ~sda_s;
    stop_c     = scl_now & scl_prev_q & ~sda_prev_q & sda_s;
  end

  // Idle bus reads as both lines high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

endmodule

// File: rtl/i2c_reg16_target.sv
// I2C target exposing a 16-bit auto-incrementing register pointer and byte data bus.
module i2c_reg16_target
  import i2c_reg16_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h30,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe,
  output logic                busy,
  i2c_reg16_target_if.master  rbus
);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic              ld_q, ld_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rx_byte;
  logic              last_bit;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    we_d      = 1'b0;
    rd_d      = 1'b0;
    ld_d      = rd_q;
    busy_d    = busy_q;
    rx_byte   = {shift_q[DATA_W-2:0], sda_s};
    last_bit  = (bit_cnt_q == CNT_W'(7));

    // Register read data arrives one cycle after the request
    if (ld_q) shift_d = rbus.reg_rdata;

    if (stop_c) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_c) begin
      state_d   = ST_DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_DEVADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WDATA: begin
          if (scl_rise_c) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              case (state_q)
                ST_DEVADDR: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = ST_ACK_DEV;
                    rw_d    = rx_byte[0];
                    rd_d    = rx_byte[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                  end
                end
                ST_ADDR_HI: begin
                  addr_d[15:8] = rx_byte;
                  state_d      = ST_ACK_HI;
                end
                ST_ADDR_LO: begin
                  addr_d[7:0] = rx_byte;
                  state_d     = ST_ACK_LO;
                end
                default: begin
                  wdata_d = rx_byte;
                  we_d    = 1'b1;
                  state_d = ST_ACK_W;
                end
              endcase
            end
          end
        end
        // First fall pulls SDA low for the ACK, second fall ends the ACK slot
        ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_W: begin
          if (scl_fall_c) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~I2C_ACK;
            end else begin
              sda_oe_d = 1'b0;
              case (state_q)
                ST_ACK_DEV: begin
                  if (rw_q) begin
                    state_d  = ST_RDATA;
                    sda_oe_d = ~shift_q[DATA_W-1];
                    shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                  end else begin
                    state_d = ST_ADDR_HI;
                  end
                end
                ST_ACK_HI: state_d = ST_ADDR_LO;
                ST_ACK_LO: state_d = ST_WDATA;
                default: begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = ST_WDATA;
                end
              endcase
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall_c) begin
            sda_oe_d = ~shift_q[DATA_W-1];
            shift_d  = {shift_q[DATA_W-2:0], 1'b0};
          end else if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit) state_d = ST_MACK;
          end
        end
        ST_MACK: begin
          if (scl_fall_c) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise_c) begin
            if (sda_s == I2C_NACK) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              rd_d    = 1'b1;
              state_d = ST_RDATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      ld_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      ld_q      <= ld_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe          = sda_oe_q;
  assign busy            = busy_q;
  assign rbus.reg_addr   = addr_q;
  assign rbus.reg_wdata  = wdata_q;
  assign rbus.reg_we     = we_q;
  assign rbus.reg_rd     = rd_q;

endmodule

// File: tb/tb_i2c_reg16_target.sv
// Bench for i2c_reg16_target: bit-banged I2C master, register model, we/rd scoreboard.
module tb_i2c_reg16_target;

  localparam int unsigned Q = 60;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_oe, busy, sda_line;

  assign sda_line = m_sda & ~sda_oe;

  i2c_reg16_target_if rbus();

  i2c_reg16_target #(.DEV_ADDR(7'h30), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (m_scl),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .busy   (busy),
    .rbus   (rbus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (rst) rbus.reg_rdata <= 8'h00;
    else begin
      if (rbus.reg_we) mem[rbus.reg_addr] <= rbus.reg_wdata;
      if (rbus.reg_rd) rbus.reg_rdata <= mem[rbus.reg_addr];
    end
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } we_t;

  we_t         exp_we[$];
  logic [15:0] exp_rd[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, nothing expected", name, act);
  endtask

  task automatic monitor();
    we_t         e;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rbus.reg_we && rbus.reg_rd) fail_unexp("we_rd_same_cycle", 32'(rbus.reg_addr));
        if (rbus.reg_we) begin
          if (exp_we.size() == 0) fail_unexp("we_unexpected", {8'h00, rbus.reg_addr, rbus.reg_wdata});
          else begin
            e = exp_we.pop_front();
            check("we_addr", 32'(rbus.reg_addr), 32'(e.addr));
            check("we_data", 32'(rbus.reg_wdata), 32'(e.data));
          end
        end
        if (rbus.reg_rd) begin
          if (exp_rd.size() == 0) fail_unexp("rd_unexpected", 32'(rbus.reg_addr));
          else begin
            a = exp_rd.pop_front();
            check("rd_addr", 32'(rbus.reg_addr), 32'(a));
          end
        end
      end
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = sda_line; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input string name, input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    check(name, 32'(a), 32'(exp_ack));
  endtask

  task automatic recv_byte(input string name, input logic [7:0] exp, input logic m_ack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    check(name, 32'(d), 32'(exp));
    put_bit(m_ack);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(rbus.reg_addr), 0);
    check("rst_wdata", 32'(rbus.reg_wdata), 0);
    check("rst_we", 32'(rbus.reg_we), 0);
    check("rst_rd", 32'(rbus.reg_rd), 0);
    rst = 1'b0;
    #(2*Q);

    // Single write 0x01 to 0x0103
    exp_we.push_back({16'h0103, 8'h01});
    i2c_start();
    send_byte("t1_dev_ack", 8'h60, 1'b0);
    check("t1_busy", 32'(busy), 1);
    send_byte("t1_ahi_ack", 8'h01, 1'b0);
    send_byte("t1_alo_ack", 8'h03, 1'b0);
    send_byte("t1_data_ack", 8'h01, 1'b0);
    i2c_stop();
    check("t1_busy_after_stop", 32'(busy), 0);

    // Wrong device address is NACKed
    i2c_start();
    send_byte("t2_dev_nack", 8'h62, 1'b1);
    check("t2_busy", 32'(busy), 0);
    i2c_stop();

    // Burst write at 0x3e01
    exp_we.push_back({16'h3e01, 8'h40});
    exp_we.push_back({16'h3e02, 8'h50});
    exp_we.push_back({16'h3e03, 8'h0b});
    i2c_start();
    send_byte("t3_dev_ack", 8'h60, 1'b0);
    send_byte("t3_ahi_ack", 8'h3e, 1'b0);
    send_byte("t3_alo_ack", 8'h01, 1'b0);
    send_byte("t3_d0_ack", 8'h40, 1'b0);
    send_byte("t3_d1_ack", 8'h50, 1'b0);
    send_byte("t3_d2_ack", 8'h0b, 1'b0);
    i2c_stop();

    // Place 0xA5 at 0x3e01 so the read-back returns A5 then 0x50
    exp_we.push_back({16'h3e01, 8'ha5});
    i2c_start();
    send_byte("t4a_dev_ack", 8'h60, 1'b0);
    send_byte("t4a_ahi_ack", 8'h3e, 1'b0);
    send_byte("t4a_alo_ack", 8'h01, 1'b0);
    send_byte("t4a_d_ack", 8'ha5, 1'b0);
    i2c_stop();

    // Set pointer, repeated START, read two bytes
    i2c_start();
    send_byte("t4_dev_ack", 8'h60, 1'b0);
    send_byte("t4_ahi_ack", 8'h3e, 1'b0);
    send_byte("t4_alo_ack", 8'h01, 1'b0);
    exp_rd.push_back(16'h3e01);
    i2c_start();
    send_byte("t4_rdev_ack", 8'h61, 1'b0);
    exp_rd.push_back(16'h3e02);
    recv_byte("t4_rd0", 8'ha5, 1'b0);
    recv_byte("t4_rd1", 8'h50, 1'b1);
    check("t4_busy_after_nack", 32'(busy), 0);
    check("t4_sda_released", 32'(sda_oe), 0);
    i2c_stop();
    check("t4_busy_after_stop", 32'(busy), 0);

    // Pointer wrap
    exp_we.push_back({16'hffff, 8'h11});
    exp_we.push_back({16'h0000, 8'h22});
    i2c_start();
    send_byte("t5_dev_ack", 8'h60, 1'b0);
    send_byte("t5_ahi_ack", 8'hff, 1'b0);
    send_byte("t5_alo_ack", 8'hff, 1'b0);
    send_byte("t5_d0_ack", 8'h11, 1'b0);
    send_byte("t5_d1_ack", 8'h22, 1'b0);
    i2c_stop();
    check("t5_addr_wrapped", 32'(rbus.reg_addr), 32'h0001);

    // Reset during the device-address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 6 || i == 5);
    check("t6_ack_driven", 32'(sda_oe), 1);
    rst = 1'b1;
    #1;
    check("t6_async_release", 32'(sda_oe), 0);
    check("t6_busy_reset", 32'(busy), 0);
    check("t6_addr_reset", 32'(rbus.reg_addr), 0);
    #9;
    #20;
    rst = 1'b0;
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(2*Q);
    i2c_start();
    send_byte("t6_dev_ack", 8'h60, 1'b0);
    check("t6_busy", 32'(busy), 1);
    i2c_stop();

    #(4*Q);
    check("we_queue_drained", 32'(exp_we.size()), 0);
    check("rd_queue_drained", 32'(exp_rd.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_reg16_target.md
I2C_REG16_TARGET -- requirements
Module: i2c_reg16_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h30: the 7-bit I2C device address this block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: the number of synchronizer flops on scl_i and sda_i (minimum 2).
REQ-003 SHALL have port clk, input, 1: the single system clock, at least 16x the SCL frequency.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port scl_i, input, 1: I2C clock line as seen at the pad.
REQ-006 SHALL have port sda_i, input, 1: I2C data line as seen at the pad.
REQ-007 SHALL have port sda_oe, output, 1: SDA pull-low enable; 1 drives the line low, 0 releases it (open-drain).
REQ-008 SHALL have port reg_addr, output, 16: current register pointer.
REQ-009 SHALL have port reg_wdata, output, 8: write data, valid while reg_we=1.
REQ-010 SHALL have port reg_we, output, 1: one-cycle write strobe.
REQ-011 SHALL have port reg_rd, output, 1: one-cycle read request.
REQ-012 SHALL have port reg_rdata, input, 8: read data, valid exactly 1 clk after reg_rd.
REQ-013 SHALL have port busy, output, 1: high from a START addressed to DEV_ADDR until the next STOP or a NACK termination.

Function
REQ-014 SHALL synchronize scl_i/sda_i through SYNC_STAGES flops and SHALL derive single-cycle scl_rise/scl_fall from the synchronized SCL.
REQ-015 SHALL detect START (SDA falling while SCL=1) and STOP (SDA rising while SCL=1) in any state; START SHALL abort the current byte and enter DEVADDR; STOP SHALL enter IDLE.
REQ-016 SHALL sample SDA on scl_rise and change sda_oe only on scl_fall (+0 clk); the MSB is first.
REQ-017 FSM states: IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO, WDATA, ACK_W, RDATA, MACK.
REQ-018 DEVADDR: after 8 bits, a match with R/W=0 goes to ACK_DEV then ADDR_HI; a match with R/W=1 goes to ACK_DEV, issues reg_rd, then RDATA; a mismatch releases SDA (NACK) and goes to IDLE until the next START.
REQ-019 ACK_* states SHALL hold sda_oe=1 from the scl_fall after bit 8 until the next scl_fall.
REQ-020 ADDR_HI then ADDR_LO SHALL load reg_addr[15:8] and reg_addr[7:0]; after ACK_LO, the FSM goes to WDATA.
REQ-021 WDATA: on the 8th scl_rise, SHALL pulse reg_we for 1 clk with reg_addr/reg_wdata stable, then ACK_W; reg_addr SHALL increment at the end of ACK_W, and the FSM returns to WDATA.
REQ-022 RDATA: reg_rd SHALL be pulsed on entry; reg_rdata SHALL be latched into a shift register 1 clk later, before the first data scl_fall; sda_oe=~bit.
REQ-023 MACK: the master's bit SHALL be sampled on scl_rise; ACK (0) increments reg_addr, pulses reg_rd, and returns to RDATA; NACK (1) releases SDA and goes to IDLE.
REQ-024 reg_addr SHALL wrap 16'hFFFF -> 16'h0000; the pointer SHALL persist across transactions, so a repeated START with R/W=1 reads from the written pointer.
REQ-025 reg_we and reg_rd SHALL never be asserted in the same cycle.

Reset
REQ-026 On rst, the state SHALL be IDLE and sda_oe=0, reg_we=0, reg_rd=0, busy=0, reg_addr=16'h0000, reg_wdata=8'h00, and all synchronizer flops SHALL be set to 1 (bus idle).
REQ-027 rst asserted mid-transfer SHALL release SDA within 0 clk (asynchronously).

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the ACK/NACK constants.
REQ-029 A sub-module i2c_line_sync (synchronizer plus edge, START and STOP detection) SHALL be instantiated once.

Verification
REQ-030 Write 0x30/W, 0x01,0x03, 0x01 -> 4 ACKs; one reg_we with reg_addr=16'h0103, reg_wdata=8'h01.
REQ-031 Address 0x31/W -> NACK on bit 9, no reg_we/reg_rd, busy=0.
REQ-032 Burst write 0x3e01: 0x40,0x50,0x0b -> reg_we at 16'h3e01/02/03 carrying 8'h40/8'h50/8'h0b.
REQ-033 Write pointer 0x3e01, repeated START 0x30/R with reg_rdata=8'hA5, master ACK then NACK -> SDA shows 0xA5 then the data at 16'h3e02; STOP -> IDLE.
REQ-034 Pointer 16'hFFFF burst write of 2 bytes -> reg_we at 16'hFFFF then 16'h0000.
REQ-035 rst pulsed during ACK_DEV -> sda_oe=0 immediately; the next START+0x30 is ACKed normally.
